// File: rtl/alu_pkg.sv
// Shared types for the ALU operand stage: operand-tracking state encoding and default width.
package alu_pkg;

  localparam int ALU_WIDTH_DEF = 8;

  // bit0 = A loaded since last consume, bit1 = B loaded since last consume
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    A_ONLY = 2'b01,
    B_ONLY = 2'b10,
    FULL   = 2'b11
  } opstage_state_t;

endpackage

// File: rtl/operand_reg.sv
// Single operand register with zero / load / invert-on-load controls; zero wins over load.
module operand_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             zero,
  input  logic             inv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (zero) begin
      val_d = '0;
    end else if (ld) begin
      val_d = inv ? ~din : din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign dout = val_q;

endmodule

// File: rtl/alu_operand_stage.sv
// A/B operand holding stage ahead of the ALU with valid/consume tracking.
// Optional operand exchange enabled by defining ALU_OPSTAGE_SWAP_EN.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF,
  parameter int NSRC  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      a_src,
  input  logic                  a_we,
  input  logic                  a_zero,
  input  logic [NSRC*WIDTH-1:0] b_src,
  input  logic [NSRC-1:0]       b_we,
  input  logic                  b_inv,
  input  logic                  consume,
`ifdef ALU_OPSTAGE_SWAP_EN
  input  logic                  swap,
`endif
  output logic [WIDTH-1:0]      a_out,
  output logic [WIDTH-1:0]      b_out,
  output logic                  out_valid,
  output logic                  ovr
);

  logic [WIDTH-1:0] b_sel;
  logic             a_ld;
  logic             b_ld;
  logic             swap_eff;
  logic             retire;
  logic             a_flag;
  logic             b_flag;
  opstage_state_t   state_d;
  opstage_state_t   state_q;
  logic             ovr_d;
  logic             ovr_q;
  logic             out_valid_d;
  logic             out_valid_q;

  // Scan from the top down so the lowest enabled index is the last to assign.
  always_comb begin
    b_sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (b_we[i]) begin
        b_sel = b_src[i*WIDTH +: WIDTH];
      end
    end
  end

  assign a_ld = a_we | a_zero;
  assign b_ld = |b_we;

`ifdef ALU_OPSTAGE_SWAP_EN
  assign swap_eff = swap & ~a_ld & ~b_ld;
`else
  assign swap_eff = 1'b0;
`endif

  operand_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clk   (clk),
    .reset (reset),
    .ld    (a_we | swap_eff),
    .zero  (a_zero),
    .inv   (1'b0),
    .din   (swap_eff ? b_out : a_src),
    .dout  (a_out)
  );

  operand_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk   (clk),
    .reset (reset),
    .ld    (b_ld | swap_eff),
    .zero  (1'b0),
    .inv   (b_inv & b_ld),
    .din   (swap_eff ? a_out : b_sel),
    .dout  (b_out)
  );

  // Retire first, then exchange, then let this cycle's loads set their flags.
  always_comb begin
    retire = consume & (state_q == FULL);
    a_flag = state_q[0] & ~retire;
    b_flag = state_q[1] & ~retire;
    if (swap_eff) begin
      {a_flag, b_flag} = {b_flag, a_flag};
    end
    a_flag      = a_flag | a_ld;
    b_flag      = b_flag | b_ld;
    state_d     = opstage_state_t'({b_flag, a_flag});
    out_valid_d = (state_d == FULL);
    ovr_d       = ~retire & ((a_ld & state_q[0]) | (b_ld & state_q[1]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      ovr_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ovr_q       <= ovr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed bench for alu_operand_stage against a flag/value reference model.
module tb_alu_operand_stage;

  localparam int W  = 8;
  localparam int NS = 3;
  localparam int WW = 16;
  localparam int WN = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0]    a_src;
  logic            a_we, a_zero, b_inv, consume, swap;
  logic [NS*W-1:0] b_src;
  logic [NS-1:0]   b_we;
  logic [W-1:0]    a_out, b_out;
  logic            out_valid, ovr;

  logic [WW-1:0]    w_a_src;
  logic             w_a_we, w_a_zero, w_b_inv, w_consume, w_swap;
  logic [WN*WW-1:0] w_b_src;
  logic [WN-1:0]    w_b_we;
  logic [WW-1:0]    w_a_out, w_b_out;
  logic             w_out_valid, w_ovr;

  alu_operand_stage #(.WIDTH(W), .NSRC(NS)) dut (
    .clk(clk), .reset(reset), .a_src(a_src), .a_we(a_we), .a_zero(a_zero),
    .b_src(b_src), .b_we(b_we), .b_inv(b_inv), .consume(consume),
`ifdef ALU_OPSTAGE_SWAP_EN
    .swap(swap),
`endif
    .a_out(a_out), .b_out(b_out), .out_valid(out_valid), .ovr(ovr)
  );

  alu_operand_stage #(.WIDTH(WW), .NSRC(WN)) dut_w (
    .clk(clk), .reset(reset), .a_src(w_a_src), .a_we(w_a_we), .a_zero(w_a_zero),
    .b_src(w_b_src), .b_we(w_b_we), .b_inv(w_b_inv), .consume(w_consume),
`ifdef ALU_OPSTAGE_SWAP_EN
    .swap(w_swap),
`endif
    .a_out(w_a_out), .b_out(w_b_out), .out_valid(w_out_valid), .ovr(w_ovr)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: operand values plus "loaded since last consume" booleans.
  logic [W-1:0] ma, mb;
  bit           mav, mbv, movr;

  task automatic model_reset();
    ma = '0; mb = '0; mav = 0; mbv = 0; movr = 0;
  endtask

  task automatic drive(input bit i_a_we, input bit i_a_zero, input logic [W-1:0] i_a_src,
                       input logic [NS-1:0] i_b_we, input bit i_b_inv,
                       input logic [NS*W-1:0] i_b_src, input bit i_consume, input bit i_swap);
    bit aload, bload, retire, na, nb, t;
    logic [W-1:0] tv;
    a_we = i_a_we; a_zero = i_a_zero; a_src = i_a_src; b_we = i_b_we; b_inv = i_b_inv;
    b_src = i_b_src; consume = i_consume; swap = i_swap;
    @(posedge clk);
    aload  = i_a_we || i_a_zero;
    bload  = (i_b_we != 0);
    retire = i_consume && mav && mbv;
    movr   = !retire && ((aload && mav) || (bload && mbv));
    na = retire ? 0 : mav;
    nb = retire ? 0 : mbv;
`ifdef ALU_OPSTAGE_SWAP_EN
    if (i_swap && !aload && !bload) begin
      tv = ma; ma = mb; mb = tv;
      t = na; na = nb; nb = t;
    end
`endif
    if (i_a_zero) ma = '0;
    else if (i_a_we) ma = i_a_src;
    if (bload) begin
      for (int k = 0; k < NS; k++) begin
        if (i_b_we[k]) begin
          tv = i_b_src[k*W +: W];
          mb = i_b_inv ? ~tv : tv;
          break;
        end
      end
    end
    mav = na || aload;
    mbv = nb || bload;
    #1;
    a_we = 0; a_zero = 0; b_we = '0; b_inv = 0; consume = 0; swap = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_we = 0; a_zero = 0; a_src = '0; b_we = '0; b_inv = 0; b_src = '0; consume = 0; swap = 0;
    w_a_we = 0; w_a_zero = 0; w_a_src = '0; w_b_we = '0; w_b_inv = 0; w_b_src = '0;
    w_consume = 0; w_swap = 0;
    model_reset();
    #3;
    vectors++;
    if ({a_out, b_out, out_valid, ovr} !== {ma, mb, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_init got %h/%h v=%b o=%b required 00/00 v=0 o=0", a_out, b_out, out_valid, ovr);
    end
    @(negedge clk); reset = 1'b1;
    // Reach FULL with A=0x5A, then reset asynchronously between edges.
    drive(1, 0, 8'h5A, 3'b001, 0, 24'h0000C3, 0, 0);
    vectors++;
    if ({a_out, b_out, out_valid} !== {ma, mb, mav && mbv} || a_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_prefill got %h/%h v=%b required %h/%h v=%b", a_out, b_out, out_valid, ma, mb, mav && mbv);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({a_out, b_out, out_valid, ovr} !== {ma, mb, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async got %h/%h v=%b o=%b required 00/00 v=0 o=0", a_out, b_out, out_valid, ovr);
    end
    @(negedge clk); reset = 1'b1;
    drive(0, 0, '0, '0, 0, '0, 0, 0);
    vectors++;
    if (out_valid !== 1'b0 || a_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release got v=%b a=%h required v=0 a=00", out_valid, a_out);
    end
  endtask

  task automatic test_basic_load();
    drive(1, 0, 8'h12, '0, 0, '0, 0, 0);
    vectors++;
    if ({a_out, out_valid, ovr} !== {8'h12, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL load_a got a=%h v=%b o=%b required a=12 v=0 o=0", a_out, out_valid, ovr);
    end
    drive(0, 0, '0, 3'b010, 0, 24'h003400, 0, 0);
    vectors++;
    if ({a_out, b_out, out_valid, ovr} !== {8'h12, 8'h34, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL load_b got %h/%h v=%b o=%b required 12/34 v=1 o=0", a_out, b_out, out_valid, ovr);
    end
    drive(0, 0, '0, '0, 0, '0, 1, 0);
    vectors++;
    if ({a_out, b_out, out_valid, ovr} !== {8'h12, 8'h34, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL consume_hold got %h/%h v=%b o=%b required 12/34 v=0 o=0", a_out, b_out, out_valid, ovr);
    end
  endtask

  task automatic test_priority_inv();
    drive(0, 0, '0, 3'b011, 1, 24'h000FF0, 0, 0);
    vectors++;
    if (b_out !== 8'h0F || b_out !== mb) begin
      miscompares++;
      $display("FAIL b_prio_inv got b=%h required 0f", b_out);
    end
    drive(1, 1, 8'hFF, '0, 0, '0, 0, 0);
    vectors++;
    if ({a_out, out_valid} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL a_zero_wins got a=%h v=%b required a=00 v=1", a_out, out_valid);
    end
  endtask

  task automatic test_ovr();
    drive(1, 0, 8'h77, '0, 0, '0, 0, 0);
    vectors++;
    if ({a_out, out_valid, ovr} !== {8'h77, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ovr_pulse got a=%h v=%b o=%b required a=77 v=1 o=1", a_out, out_valid, ovr);
    end
    drive(0, 0, '0, '0, 0, '0, 0, 0);
    vectors++;
    if ({out_valid, ovr} !== 2'b10) begin
      miscompares++;
      $display("FAIL ovr_one_cycle got v=%b o=%b required v=1 o=0", out_valid, ovr);
    end
    drive(1, 0, 8'h99, '0, 0, '0, 1, 0);
    vectors++;
    if ({a_out, out_valid, ovr} !== {8'h99, 1'b0, 1'b0} || !(mav && !mbv)) begin
      miscompares++;
      $display("FAIL consume_reload got a=%h v=%b o=%b required a=99 v=0 o=0", a_out, out_valid, ovr);
    end
    // A-only: a B load must complete the pair, proving the state was A_ONLY.
    drive(0, 0, '0, 3'b100, 0, 24'h560000, 0, 0);
    vectors++;
    if ({b_out, out_valid, ovr} !== {8'h56, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL a_only_then_b got b=%h v=%b o=%b required b=56 v=1 o=0", b_out, out_valid, ovr);
    end
  endtask

  task automatic test_consume_empty();
    drive(0, 0, '0, '0, 0, '0, 1, 0);
    drive(0, 0, '0, '0, 0, '0, 1, 0);
    vectors++;
    if ({a_out, b_out, out_valid, ovr} !== {ma, mb, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL consume_empty got %h/%h v=%b o=%b required %h/%h v=0 o=0", a_out, b_out, out_valid, ovr, ma, mb);
    end
  endtask

  task automatic test_wide();
    w_b_we = 4'b1000; w_b_src = 64'hBEEF_0000_0000_0000;
    @(posedge clk); #1; w_b_we = '0;
    vectors++;
    if ({w_b_out, w_out_valid, w_ovr} !== {16'hBEEF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL wide_src3 got b=%h v=%b o=%b required b=beef v=0 o=0", w_b_out, w_out_valid, w_ovr);
    end
    w_b_we = 4'b1100; w_b_src = 64'hBEEF_1234_0000_0000; w_a_we = 1; w_a_src = 16'hCAFE;
    @(posedge clk); #1; w_b_we = '0; w_a_we = 0;
    vectors++;
    if ({w_a_out, w_b_out, w_out_valid, w_ovr} !== {16'hCAFE, 16'h1234, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL wide_prio got %h/%h v=%b o=%b required cafe/1234 v=1 o=1", w_a_out, w_b_out, w_out_valid, w_ovr);
    end
  endtask

  task automatic test_swap();
`ifdef ALU_OPSTAGE_SWAP_EN
    drive(0, 0, '0, 3'b001, 0, 24'h000022, 0, 0);
    drive(1, 0, 8'h11, '0, 0, '0, 0, 0);
    drive(1, 0, 8'h11, '0, 0, '0, 1, 0);
    drive(0, 0, '0, '0, 0, '0, 0, 1);
    vectors++;
    if ({a_out, b_out, out_valid, ovr} !== {8'h22, 8'h11, 1'b0, 1'b0} || !(mbv && !mav)) begin
      miscompares++;
      $display("FAIL swap_basic got %h/%h v=%b o=%b required 22/11 v=0 o=0", a_out, b_out, out_valid, ovr);
    end
    drive(0, 0, '0, 3'b001, 0, 24'h000033, 0, 1);
    vectors++;
    if ({a_out, b_out, out_valid, ovr} !== {8'h22, 8'h33, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL swap_vs_load got %h/%h v=%b o=%b required 22/33 v=0 o=1", a_out, b_out, out_valid, ovr);
    end
`endif
  endtask

  task automatic test_random();
    logic [NS-1:0] bw;
    for (int n = 0; n < 300; n++) begin
      bw = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, W'($urandom), bw,
            $urandom_range(0, 1) == 1, (NS*W)'({$urandom, $urandom}),
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      vectors++;
      if ({a_out, b_out, out_valid, ovr} !== {ma, mb, mav && mbv, movr}) begin
        miscompares++;
        $display("FAIL random[%0d] got %h/%h v=%b o=%b required %h/%h v=%b o=%b",
                 n, a_out, b_out, out_valid, ovr, ma, mb, mav && mbv, movr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_priority_inv();
    test_ovr();
    test_consume_empty();
    test_wide();
    test_swap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
